// File: rtl/rv_core_pkg.sv
// Shared core types: register-file geometry and the write-back request payload.
package rv_core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests with occupancy count; depth must be a power of two.
module wb_fifo
  import rv_core_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_req_t       din,
  input  logic          pop,
  output wb_req_t       head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port master: ALU results take priority over buffered load returns,
// with a pending-load scoreboard exposed to decode for RAW hazard detection.
module rf_writeback_arbiter
  import rv_core_pkg::*;
#(
  parameter  int unsigned LQ_DEPTH = 2,
  localparam int unsigned CW       = $clog2(LQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  input  logic              iss_ld_valid,
  input  logic [REG_AW-1:0] iss_ld_rd,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [XLEN-1:0]   WriteData,
  output logic [CW-1:0]     lq_count
);

  wb_req_t           lq_head;
  wb_req_t           lq_din;
  logic              lq_full;
  logic              lq_empty;
  logic              lq_push;
  logic              lq_pop;

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;

  logic              reg_write_nxt;
  logic [REG_AW-1:0] write_reg_nxt;
  logic [XLEN-1:0]   write_data_nxt;

  assign ld_ready = !lq_full;
  assign lq_push  = ld_valid && ld_ready;
  assign lq_pop   = !alu_wb_valid && !lq_empty;
  assign lq_din   = '{rd: ld_rd, data: ld_data};

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lq_push),
    .din   (lq_din),
    .pop   (lq_pop),
    .head  (lq_head),
    .count (lq_count),
    .full  (lq_full),
    .empty (lq_empty)
  );

  // Write-port arbitration: ALU first, then FIFO head; idle holds address/data.
  always_comb begin
    reg_write_nxt  = 1'b0;
    write_reg_nxt  = WriteReg;
    write_data_nxt = WriteData;
    if (alu_wb_valid) begin
      reg_write_nxt  = (alu_wb_rd != '0);
      write_reg_nxt  = alu_wb_rd;
      write_data_nxt = alu_wb_data;
    end else if (lq_pop) begin
      reg_write_nxt  = (lq_head.rd != '0);
      write_reg_nxt  = lq_head.rd;
      write_data_nxt = lq_head.data;
    end
  end

  // Scoreboard update; a same-cycle issue overrides the retiring load's clear.
  always_comb begin
    pending_nxt = pending;
    if (lq_pop) pending_nxt[lq_head.rd] = 1'b0;
    if (iss_ld_valid && (iss_ld_rd != '0)) pending_nxt[iss_ld_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      pending   <= '0;
    end else begin
      RegWrite  <= reg_write_nxt;
      WriteReg  <= write_reg_nxt;
      WriteData <= write_data_nxt;
      pending   <= pending_nxt;
    end
  end

  assign rs1_busy = pending[chk_rs1];
  assign rs2_busy = pending[chk_rs2];

endmodule
